// File: rtl/fifo_uart_drain.sv
// Purpose: pops 15-bit words from a registered-read FIFO and sends each out a
//   UART TX line as two 8N1 frames, low byte first; counts words sent.
// Latency: ren in cycle N, start bit from N+2, word done (count++) at N+2+20*CLKS_PER_BIT.
// Backpressure: pops only in IDLE when enable=1 and empty=0; busy covers the whole word.
// Ports: clock, reset (sync, active-high), enable, empty, dataIn[14:0] (in);
//   ren, tx, busy, word_count[COUNT_W-1:0] (out).
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 434,
  parameter int COUNT_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               empty,
  input  logic [14:0]        dataIn,
  output logic               ren,
  output logic               tx,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic              byte_sel;
  logic [14:0]       word_q;
  logic [7:0]        shreg;
  logic              bit_done;

  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ren/busy assert in the same cycle the pop decision is made so the
  // FIFO's registered read data lands in LOAD.
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    tx      = 1'b1;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (!reset && enable && !empty) begin
          ren     = 1'b1;
          busy    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_done && (bit_cnt == 3'd7)) state_d = STOP;
      end
      STOP: begin
        tx = 1'b1;
        if (bit_done) state_d = byte_sel ? IDLE : START;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_sel   <= 1'b0;
      word_q     <= '0;
      shreg      <= '0;
      word_count <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          word_q   <= dataIn;
          byte_sel <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            // The frame byte is loaded at the end of the start bit so both
            // frames share one load point.
            shreg    <= byte_sel ? {1'b0, word_q[14:8]} : word_q[7:0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            shreg    <= {1'b0, shreg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
            end else begin
              word_count <= word_count + COUNT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: directed scenarios then random traffic, every
// cycle compared against a word-level timing model of the UART drain.
module tb_fifo_uart_drain;
  localparam int C  = 4;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          empty;
  logic [14:0]   dataIn;
  logic          ren;
  logic          tx;
  logic          busy;
  logic [CW-1:0] word_count;

  fifo_uart_drain #(.CLKS_PER_BIT(C), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .empty(empty),
    .dataIn(dataIn), .ren(ren), .tx(tx), .busy(busy), .word_count(word_count)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [14:0] fifo_q[$];
  int          ren_log[$];
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [14:0] m_word = '0;
  int          m_count = 0;
  bit          ren_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line level for offset j into the 20-bit-period word transmission.
  function automatic logic exp_tx_bit(input logic [14:0] w, input int j);
    int frame;
    int b;
    logic [7:0] by;
    frame = j / (10 * C);
    b     = (j % (10 * C)) / C;
    by    = (frame == 0) ? w[7:0] : {1'b0, w[14:8]};
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[3'(b - 1)];
  endfunction

  task automatic push(input logic [14:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock cycle: check at negedge, then model FIFO read at posedge+1.
  task automatic tick();
    int   off;
    logic e_tx;
    @(negedge clock);
    if (!m_active && !reset && enable && !empty) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_word   = fifo_q[0];
    end
    off  = cyc - m_start;
    e_tx = 1'b1;
    if (m_active && off >= 2) e_tx = exp_tx_bit(m_word, off - 2);
    if (!reset) begin
      chk("ren", ren, m_active && off == 0);
      chk("busy", busy, m_active);
      chk("tx", tx, e_tx);
      chk("word_count", word_count, m_count);
    end
    ren_s = (ren === 1'b1);
    if (ren_s) ren_log.push_back(cyc);
    if (reset) begin
      m_active = 1'b0;
      m_count  = 0;
    end else if (m_active && off == 1 + 20 * C) begin
      m_active = 1'b0;
      m_count  = (m_count + 1) % (1 << CW);
    end
    @(posedge clock);
    #1;
    cyc++;
    if (ren_s && fifo_q.size() > 0) dataIn = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((busy !== 1'b0 || (enable && fifo_q.size() > 0)) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < max, 1);
  endtask

  initial begin
    int base;
    reset = 1'b1; enable = 1'b0; empty = 1'b1; dataIn = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ren", ren, 0);
    chk("rst_wc", word_count, 0);
    enable = 1'b1;
    repeat (50) tick();
    chk("idle_no_ren", ren_log.size(), 0);

    // Single word
    base = ren_log.size();
    push(15'h1234);
    drain(200);
    chk("single_ren_cnt", ren_log.size() - base, 1);
    chk("single_latency", cyc - ren_log[base], 82);
    chk("single_wc", word_count, 1);

    // Back-to-back
    enable = 1'b0;
    push(15'h7FFF); push(15'h0000); push(15'h4A5B);
    enable = 1'b1;
    base = ren_log.size();
    drain(400);
    chk("b2b_ren_cnt", ren_log.size() - base, 3);
    chk("b2b_gap1", ren_log[base + 1] - ren_log[base], 82);
    chk("b2b_gap2", ren_log[base + 2] - ren_log[base + 1], 82);
    chk("b2b_wc", word_count, 4 % (1 << CW));

    // Enable drop mid-word
    enable = 1'b0;
    push(15'h2AAA); push(15'h1555);
    enable = 1'b1;
    base = ren_log.size();
    repeat (30) tick();
    enable = 1'b0;
    repeat (200) tick();
    chk("endrop_ren_cnt", ren_log.size() - base, 1);
    chk("endrop_left", fifo_q.size(), 1);
    chk("endrop_wc", word_count, 5 % (1 << CW));

    // Reset mid-frame
    push(15'h0F0F);
    enable = 1'b1;
    base = ren_log.size();
    repeat (20) tick();
    chk("midrst_busy_before", busy, 1);
    reset = 1'b1; enable = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_wc", word_count, 0);
    chk("midrst_left", fifo_q.size(), 1);
    enable = 1'b1;
    drain(200);
    chk("midrst_ren_cnt", ren_log.size() - base, 2);
    chk("midrst_wc_after", word_count, 1);

    // Counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push(15'($urandom));
      drain(200);
      chk("wrap_wc", word_count, k % (1 << CW));
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0 && fifo_q.size() < 4) push(15'($urandom));
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    enable = 1'b1;
    drain(1000);
    chk("final_empty", fifo_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
